// File: rtl/ll2_token_fifo.sv
// ll2_token_fifo: show-ahead token queue linking an actor output port to an actor input port.
// The write side raises a registered W_ACK one cycle after it accepts a token.
// Misuse is recorded in sticky ERR flags that only reset clears.
`timescale 1ns/1ps
module ll2_token_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             W_SEND,
    input  logic [WIDTH-1:0] W_DATA,
    input  logic [15:0]      W_COUNT,
    output logic             W_RDY,
    output logic             W_ACK,
    output logic             R_SEND,
    output logic [WIDTH-1:0] R_DATA,
    output logic [15:0]      R_COUNT,
    input  logic             R_ACK,
    output logic [2:0]       ERR
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full_c;
    logic             empty_c;
    logic             wr_ok_c;
    logic             rd_ok_c;
    logic [CW-1:0]    count_nxt_c;
    logic [2:0]       err_set_c;

    // Accept decisions use pre-edge occupancy for both sides
    always_comb begin
        full_c      = (count == CW'(DEPTH));
        empty_c     = (count == '0);
        wr_ok_c     = W_SEND & ~full_c;
        rd_ok_c     = R_ACK & ~empty_c;
        err_set_c   = 3'b000;
        err_set_c[0] = W_SEND & full_c;
        err_set_c[1] = R_ACK & empty_c;
        err_set_c[2] = W_SEND & (W_COUNT != 16'h0001);
        count_nxt_c = count;
        case ({wr_ok_c, rd_ok_c})
            2'b10:   count_nxt_c = count + CW'(1);
            2'b01:   count_nxt_c = count - CW'(1);
            default: count_nxt_c = count;
        endcase
    end

    // Pointers, occupancy, write acknowledge and sticky error flags
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            W_ACK  <= 1'b0;
            ERR    <= 3'b000;
        end else begin
            if (wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok_c) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt_c;
            W_ACK <= wr_ok_c;
            ERR   <= ERR | err_set_c;
        end
    end

    // Token storage is never cleared; contents past the read pointer are dead
    always_ff @(posedge CLK) begin
        if (wr_ok_c) mem[wr_ptr] <= W_DATA;
    end

    // Status and head token come from registered state only
    always_comb begin
        W_RDY   = ~full_c;
        R_SEND  = ~empty_c;
        R_COUNT = 16'(count);
        R_DATA  = mem[rd_ptr];
    end

endmodule

// File: tb/tb_ll2_token_fifo.sv
// Bench for ll2_token_fifo: directed scenarios plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_ll2_token_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 16;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             W_SEND;
    logic [WIDTH-1:0] W_DATA;
    logic [15:0]      W_COUNT;
    logic             W_RDY;
    logic             W_ACK;
    logic             R_SEND;
    logic [WIDTH-1:0] R_DATA;
    logic [15:0]      R_COUNT;
    logic             R_ACK;
    logic [2:0]       ERR;

    ll2_token_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .W_SEND(W_SEND), .W_DATA(W_DATA), .W_COUNT(W_COUNT),
        .W_RDY(W_RDY), .W_ACK(W_ACK),
        .R_SEND(R_SEND), .R_DATA(R_DATA), .R_COUNT(R_COUNT),
        .R_ACK(R_ACK), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Reference model: token queue, sticky error bits, expected ack
    logic [WIDTH-1:0] q[$];
    logic [2:0]       m_err;
    logic             m_ack;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":count"}, 32'(R_COUNT), 32'(q.size()));
        check({tag, ":w_rdy"}, 32'(W_RDY), 32'(q.size() < int'(DEPTH)));
        check({tag, ":r_send"}, 32'(R_SEND), 32'(q.size() > 0));
        check({tag, ":w_ack"}, 32'(W_ACK), 32'(m_ack));
        check({tag, ":err"}, 32'(ERR), 32'(m_err));
        if (q.size() > 0) check({tag, ":r_data"}, 32'(R_DATA), 32'(q[0]));
    endtask

    // One clock of traffic: drive, let the edge happen, update model, compare
    task automatic step(input string tag, input logic ws, input logic [15:0] wd,
                        input logic [15:0] wc, input logic ra);
        bit wr;
        bit rd;
        W_SEND = ws; W_DATA = wd; W_COUNT = wc; R_ACK = ra;
        wr = ws && (q.size() < int'(DEPTH));
        rd = ra && (q.size() > 0);
        if (ws && q.size() == int'(DEPTH)) m_err[0] = 1'b1;
        if (ra && q.size() == 0)           m_err[1] = 1'b1;
        if (ws && wc != 16'h0001)          m_err[2] = 1'b1;
        @(posedge CLK);
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(wd);
        m_ack = wr;
        #1;
        W_SEND = 1'b0; R_ACK = 1'b0; W_COUNT = 16'h0001;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        q.delete();
        m_err = 3'b000;
        m_ack = 1'b0;
        check_outputs("reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check_outputs("post_reset");
    endtask

    initial begin
        RESET_N = 1'b0; W_SEND = 1'b0; W_DATA = '0; W_COUNT = 16'h0001; R_ACK = 1'b0;
        q.delete(); m_err = 3'b000; m_ack = 1'b0;
        #3;
        do_reset();

        // Basic ordered traffic
        step("basic_w", 1'b1, 16'h00A1, 16'h1, 1'b0);
        step("basic_w", 1'b1, 16'h00A2, 16'h1, 1'b0);
        step("basic_w", 1'b1, 16'h00A3, 16'h1, 1'b0);
        for (int i = 0; i < 3; i++) step("basic_r", 1'b0, 16'h0, 16'h1, 1'b1);

        // Fill to capacity, overflow attempt, drain
        do_reset();
        for (int i = 0; i < 16; i++) step("full_w", 1'b1, 16'(i), 16'h1, 1'b0);
        step("overflow", 1'b1, 16'h00EE, 16'h1, 1'b0);
        for (int i = 0; i < 16; i++) step("full_r", 1'b0, 16'h0, 16'h1, 1'b1);

        // Steady occupancy of 5 with simultaneous push/pop across pointer wrap
        do_reset();
        for (int i = 0; i < 5; i++) step("wrap_fill", 1'b1, 16'(i), 16'h1, 1'b0);
        for (int i = 5; i < 45; i++) step("wrap_both", 1'b1, 16'(i), 16'h1, 1'b1);

        // Boundaries
        do_reset();
        step("underflow", 1'b0, 16'h0, 16'h1, 1'b1);
        step("empty_both", 1'b1, 16'h0042, 16'h1, 1'b1);
        do_reset();
        for (int i = 0; i < 16; i++) step("bfill", 1'b1, 16'(16'h100 + i), 16'h1, 1'b0);
        step("full_both", 1'b1, 16'h0BAD, 16'h1, 1'b1);
        do_reset();
        step("bad_count", 1'b1, 16'h0077, 16'h2, 1'b0);

        // Reset in the middle of a stream, with an ack pulse pending
        do_reset();
        for (int i = 0; i < 7; i++) step("mid_w", 1'b1, 16'(16'h200 + i), 16'h1, 1'b0);
        RESET_N = 1'b0;
        #1;
        q.delete(); m_err = 3'b000; m_ack = 1'b0;
        check_outputs("mid_reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        step("after_rst", 1'b1, 16'h0055, 16'h1, 1'b0);
        step("after_rst_r", 1'b0, 16'h0, 16'h1, 1'b1);

        // Random traffic: write-heavy then read-heavy to reach both extremes
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 70 : 30;
            step("rand", ($urandom_range(0, 99) < wp), 16'($urandom),
                 ($urandom_range(0, 19) == 0) ? 16'h2 : 16'h1,
                 ($urandom_range(0, 99) < (100 - wp)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ll2_token_fifo.md
LL2_TOKEN_FIFO -- requirements
Module: ll2_token_fifo

Purpose: inter-actor token queue. The write side is driven by an actor output port (SEND/DATA/COUNT in, RDY/ACK out). The read side feeds an actor input port (SEND/DATA/COUNT out, ACK in).

Interface
Parameters
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the token capacity; it is a power of two, 2..256.
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the token data width in bits.

Ports (name, direction, width, meaning)
REQ-003 CLK, input, 1: single clock; all state updates on rising edge.
REQ-004 RESET_N, input, 1: reset, asynchronous and active-low.
REQ-005 W_SEND, input, 1: producer write strobe, one token per asserted cycle.
REQ-006 W_DATA, input, WIDTH: write token, valid while W_SEND=1.
REQ-007 W_COUNT, input, 16: tokens offered this cycle; the legal value is 16'h1.
REQ-008 W_RDY, output, 1: space available; 1 when occupancy < DEPTH.
REQ-009 W_ACK, output, 1: one-cycle pulse, registered, the cycle after a write is accepted.
REQ-010 R_SEND, output, 1: token available; 1 when occupancy > 0.
REQ-011 R_DATA, output, WIDTH: head token (show-ahead); valid while R_SEND=1.
REQ-012 R_COUNT, output, 16: current occupancy, zero-extended.
REQ-013 R_ACK, input, 1: consumer pop strobe; removes the head token at the clock edge.
REQ-014 ERR, output, 3: sticky error flags. [0] overflow, [1] underflow, [2] bad W_COUNT.

Function
REQ-015 A write SHALL be accepted iff W_SEND=1 and occupancy < DEPTH, sampled before any same-cycle pop.
REQ-016 An accepted write SHALL store W_DATA at the write pointer, advance the pointer modulo DEPTH, and pulse W_ACK on the next cycle.
REQ-017 A pop SHALL be accepted iff R_ACK=1 and occupancy > 0, sampled before any same-cycle write.
REQ-018 An accepted pop SHALL advance the read pointer modulo DEPTH.
REQ-019 Simultaneous accepted write and pop SHALL leave occupancy unchanged; both pointers advance.
REQ-020 Full plus W_SEND plus R_ACK SHALL accept the pop only, reject the write, and set ERR[0]; the occupancy becomes DEPTH-1.
REQ-021 Empty plus W_SEND plus R_ACK SHALL accept the write only and set ERR[1]; the occupancy becomes 1.
REQ-022 Write latency: a token written into an empty FIFO at edge N SHALL produce R_SEND=1 with R_DATA equal to that token after edge N; no bypass in the same cycle.
REQ-023 After an accepted pop, R_DATA SHALL present the next token in the cycle following the edge; order is strictly FIFO.
REQ-024 W_RDY, R_SEND and R_COUNT SHALL be derived from registered state only, with no combinational path from W_SEND or R_ACK.
REQ-025 W_SEND=1 with W_COUNT != 1 SHALL set ERR[2]; the write is still treated as exactly one token under REQ-015.
REQ-026 A rejected write while full SHALL set ERR[0] and SHALL NOT alter storage, pointers or W_ACK.
REQ-027 A pop while empty SHALL set ERR[1] and SHALL NOT alter state.
REQ-028 ERR bits SHALL hold until reset.
REQ-029 The occupancy counter SHALL be log2(DEPTH)+1 bits wide, with pointers log2(DEPTH) bits wrapping naturally; R_COUNT never exceeds DEPTH.

Reset
REQ-030 RESET_N=0 SHALL asynchronously clear pointers, occupancy, W_ACK and ERR.
REQ-031 Reset values: W_RDY=1, R_SEND=0, R_COUNT=0, W_ACK=0, ERR=0; R_DATA is don't-care and storage is not cleared.
REQ-032 Reset asserted mid-operation SHALL discard all queued tokens; no pending W_ACK pulse is emitted after release.
REQ-033 Writes and pops SHALL take effect from the first rising edge after RESET_N deasserts.

Verification
REQ-034 Basic: after reset, write 16'h00A1, 16'h00A2, 16'h00A3 on consecutive cycles, then pop three times -> R_DATA reads A1, A2, A3 in order; R_COUNT goes 1,2,3 then 2,1,0; W_ACK pulses 3 times.
REQ-035 Full: write 16 tokens 16'h0000..16'h000F -> W_RDY=0 and R_COUNT=16; a 17th W_SEND -> ERR[0]=1 with contents unchanged; 16 pops return 0..F.
REQ-036 Wrap and simultaneous: hold occupancy at 5 while pushing and popping together for 40 cycles with incrementing data -> R_COUNT stays 5, output sequence is gap-free, ERR=0.
REQ-037 Boundaries: R_ACK on an empty FIFO -> ERR[1]=1 and R_COUNT=0. Full plus W_SEND plus R_ACK -> R_COUNT=15, ERR[0]=1. W_COUNT=16'h2 -> ERR[2]=1 with one token stored.
REQ-038 Reset mid-stream: with 7 tokens queued, pulse RESET_N low between edges -> outputs go to REQ-031 values immediately; the next write 16'h0055 is the first token read.
